// File: rtl/stage_4_mem.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack data bus,
// stalling upstream while a transaction is outstanding, with timeout abort.
module stage_4_mem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  op,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] size_of(input logic [5:0] o);
    case (o)
      6'h20, 6'h24, 6'h28: size_of = 2'd0;
      6'h21, 6'h25, 6'h29: size_of = 2'd1;
      default:             size_of = 2'd2;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0]   addr_q, addr_d;
  logic [1:0]    lane_q, lane_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   ldata_q, ldata_d;
  logic          err_q, err_d;

  logic [1:0]  size_in, size_lat, lane_in;
  logic        access, misaligned, start, is_signed;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, shifted, load_fmt;

  always_comb begin
    size_in    = size_of(op);
    lane_in    = alu_result[1:0];
    access     = valid_in & (mem_read | mem_write);
    misaligned = ((size_in == 2'd1) && lane_in[0]) ||
                 ((size_in == 2'd2) && (lane_in != 2'b00));
    start      = (state_q == S_IDLE) && access && !misaligned;

    case (size_in)
      2'd0:    be_new = 4'b0001 << lane_in;
      2'd1:    be_new = lane_in[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase

    case (size_in)
      2'd0:    wdata_new = {4{store_data[7:0]}};
      2'd1:    wdata_new = {2{store_data[15:0]}};
      default: wdata_new = store_data;
    endcase

    // Load lane extraction uses the latched op/lane, not the live inputs.
    size_lat  = size_of(op_q);
    is_signed = (op_q == 6'h20) || (op_q == 6'h21);
    shifted   = mem_rdata >> {lane_q, 3'b000};
    case (size_lat)
      2'd0:    load_fmt = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    load_fmt = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    op_d    = op_q;
    ldata_d = ldata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = alu_result[31:2];
          lane_d  = lane_in;
          be_d    = be_new;
          wdata_d = wdata_new;
          we_d    = mem_write;
          op_d    = op;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Ack takes priority over the timeout on the final wait cycle.
        if (mem_ack) begin
          ldata_d = load_fmt;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ldata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      op_q    <= op_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? {addr_q, 2'b00} : '0;
    mem_wdata = mem_req ? wdata_q : '0;
    mem_be    = mem_req ? be_q : '0;
    stall     = start | mem_req;
    addr_err  = (state_q == S_IDLE) && access && misaligned;
    bus_err   = (state_q == S_DONE) && err_q;
    case (state_q)
      S_IDLE:  wb_data = access ? '0 : alu_result;
      S_DONE:  wb_data = we_q ? alu_result : ldata_q;
      default: wb_data = '0;
    endcase
  end

endmodule

// File: tb/tb_stage_4_mem.sv
// Bench for stage_4_mem: directed scenarios plus randomized accesses checked
// against an arithmetic model of lane selection, byte enables and latency.
module tb_stage_4_mem;
  localparam int unsigned TO = 16;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_ack = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] alu_result = '0, store_data = '0, mem_rdata = '0;
  logic        mem_req, mem_we, stall, addr_err, bus_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;

  int unsigned n_tests = 0, n_fail = 0;

  logic        o_aerr, o_st0, o_berr, o_done, o_leak, o_early, o_we;
  logic [31:0] o_addr, o_wdata, o_wb;
  logic [3:0]  o_be;
  int          o_req, o_stall;

  always #5 clk = ~clk;

  stage_4_mem #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op(op), .mem_read(mem_read),
    .mem_write(mem_write), .alu_result(alu_result), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .wb_data(wb_data), .addr_err(addr_err), .bus_err(bus_err)
  );

  function automatic int unsigned nbytes(input logic [5:0] o);
    if (o == LB || o == LBU || o == SB) return 1;
    if (o == LH || o == LHU || o == SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [5:0] o, input logic [31:0] a);
    int unsigned n = nbytes(o);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] o, input logic [31:0] sd);
    logic [31:0] r;
    int unsigned n = nbytes(o);
    for (int unsigned k = 0; k < 4; k++) r[8*k +: 8] = sd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] o, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned n = nbytes(o);
    logic [31:0] v, mask;
    if (n == 4) return rd;
    mask = (n == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * (a % 4))) & mask;
    if ((o == LB || o == LH) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Presents one instruction from posedge+1 and records what the DUT does until
  // the instruction retires; returns at posedge+1 with inputs idle.
  task automatic mem_txn(input logic [5:0] o, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdat, input int ack_at);
    op = o; mem_read = rd; mem_write = wr; alu_result = a; store_data = sd;
    valid_in = 1'b1; mem_ack = 1'b0;
    o_aerr = 0; o_st0 = 0; o_berr = 0; o_done = 0; o_leak = 0; o_early = 0;
    o_we = 0; o_addr = '0; o_wdata = '0; o_wb = '0; o_be = '0; o_req = 0; o_stall = 0;
    for (int cyc = 0; cyc < int'(TO) + 8 && !o_done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin o_aerr = addr_err; o_st0 = stall; end
      if (stall) o_stall++;
      if (mem_req) begin
        o_req++;
        if (o_req == 1) begin o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata; end
        mem_ack = (o_req == ack_at);
        mem_rdata = mem_ack ? rdat : $urandom;
      end else begin
        mem_ack = 1'b0;
        if (mem_we || mem_addr != 0 || mem_wdata != 0 || mem_be != 0) o_leak = 1;
      end
      if (!stall && !mem_req) begin
        o_done = 1; o_wb = wb_data; o_berr = bus_err;
      end else if (bus_err) o_early = 1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    alu_result = 32'h55;
    #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", mem_req); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
    n_tests++; if (wb_data !== 32'h55) begin n_fail++; $display("FAIL rst_wb got %h want 00000055", wb_data); end
    n_tests++; if ({mem_we, mem_be, mem_addr, mem_wdata, bus_err} !== '0) begin
      n_fail++; $display("FAIL rst_bus got we=%b be=%h addr=%h wd=%h berr=%b want all 0",
                         mem_we, mem_be, mem_addr, mem_wdata, bus_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_release got stall=%b req=%b want 0 0", stall, mem_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    op = LW; mem_read = 1'b1; alu_result = 32'h200; valid_in = 1'b1;
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_issue_stall got %b want 1", stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req got %b want 1", mem_req); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_drop got %b want 0", mem_req); end
    valid_in = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if ({stall, mem_req, bus_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_after got stall/req/berr=%b want 000", {stall, mem_req, bus_err}); end
    @(posedge clk); #1;
  endtask

  task automatic test_sw;
    mem_txn(SW, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, '0, 2);
    n_tests++; if (o_req !== 2) begin n_fail++; $display("FAIL sw_req_cycles got %0d want 2", o_req); end
    n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h want 00000100", o_addr); end
    n_tests++; if (o_be !== 4'hF || o_we !== 1'b1) begin n_fail++; $display("FAIL sw_be_we got %h/%b want f/1", o_be, o_we); end
    n_tests++; if (o_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", o_wdata); end
    n_tests++; if (o_stall !== 3) begin n_fail++; $display("FAIL sw_stall got %0d want 3", o_stall); end
    n_tests++; if (o_done !== 1'b1 || o_berr !== 1'b0) begin n_fail++; $display("FAIL sw_done got done=%b berr=%b want 1 0", o_done, o_berr); end
    n_tests++; if (o_leak !== 1'b0) begin n_fail++; $display("FAIL sw_bus_idle got leak=%b want 0", o_leak); end
  endtask

  task automatic test_load_byte;
    mem_txn(LB, 1'b1, 1'b0, 32'h103, '0, 32'h80123456, 1);
    n_tests++; if (o_wb !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_wb got %h want ffffff80", o_wb); end
    n_tests++; if (o_addr !== 32'h100 || o_be !== 4'b1000 || o_we !== 1'b0) begin n_fail++; $display("FAIL lb_bus got addr=%h be=%h we=%b want 00000100 8 0", o_addr, o_be, o_we); end
    n_tests++; if (o_stall !== 2) begin n_fail++; $display("FAIL lb_zero_wait_stall got %0d want 2", o_stall); end
    mem_txn(LBU, 1'b1, 1'b0, 32'h103, '0, 32'h80123456, 1);
    n_tests++; if (o_wb !== 32'h00000080) begin n_fail++; $display("FAIL lbu_wb got %h want 00000080", o_wb); end
  endtask

  task automatic test_half;
    mem_txn(SH, 1'b0, 1'b1, 32'h102, 32'h0000ABCD, '0, 1);
    n_tests++; if (o_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); end
    n_tests++; if (o_be !== 4'hC) begin n_fail++; $display("FAIL sh_be got %h want c", o_be); end
    mem_txn(LH, 1'b1, 1'b0, 32'h101, '0, '0, 1);
    n_tests++; if (o_aerr !== 1'b1) begin n_fail++; $display("FAIL lh_mis_aerr got %b want 1", o_aerr); end
    n_tests++; if (o_req !== 0 || o_stall !== 0) begin n_fail++; $display("FAIL lh_mis_noreq got req=%0d stall=%0d want 0 0", o_req, o_stall); end
    n_tests++; if (o_wb !== 32'h0) begin n_fail++; $display("FAIL lh_mis_wb got %h want 0", o_wb); end
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL lh_mis_nostate got req=%b stall=%b want 0 0", mem_req, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    mem_txn(LW, 1'b1, 1'b0, 32'h40, '0, '0, 0);
    n_tests++; if (o_req !== int'(TO)) begin n_fail++; $display("FAIL to_req_cycles got %0d want %0d", o_req, TO); end
    n_tests++; if (o_done !== 1'b1 || o_berr !== 1'b1) begin n_fail++; $display("FAIL to_berr got done=%b berr=%b want 1 1", o_done, o_berr); end
    n_tests++; if (o_wb !== 32'h0) begin n_fail++; $display("FAIL to_wb got %h want 0", o_wb); end
    n_tests++; if (o_early !== 1'b0) begin n_fail++; $display("FAIL to_early_berr got %b want 0", o_early); end
    @(negedge clk);
    n_tests++; if (bus_err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL to_idle got berr=%b stall=%b want 0 0", bus_err, stall); end
    @(posedge clk); #1;
    mem_txn(LHU, 1'b1, 1'b0, 32'h46, '0, 32'h9ABC1234, int'(TO));
    n_tests++; if (o_berr !== 1'b0 || o_wb !== 32'h00009ABC) begin n_fail++; $display("FAIL ack_at_limit got berr=%b wb=%h want 0 00009abc", o_berr, o_wb); end
  endtask

  task automatic test_nonmem;
    mem_txn(6'h00, 1'b0, 1'b0, 32'h1234, '0, '0, 1);
    n_tests++; if (o_wb !== 32'h1234 || o_stall !== 0) begin n_fail++; $display("FAIL nonmem got wb=%h stall=%0d want 00001234 0", o_wb, o_stall); end
    alu_result = 32'h77; mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    n_tests++; if ({stall, mem_req, bus_err} !== 3'b000 || wb_data !== 32'h77) begin
      n_fail++; $display("FAIL spurious_ack got s/r/e=%b wb=%h want 000 00000077", {stall, mem_req, bus_err}, wb_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    mem_txn(SW, 1'b0, 1'b1, 32'h300, 32'h11223344, '0, 3);
    mem_txn(LH, 1'b1, 1'b0, 32'h302, '0, 32'hF00D1122, 2);
    n_tests++; if (o_st0 !== 1'b1 || o_stall !== 3) begin n_fail++; $display("FAIL b2b_issue got st0=%b stall=%0d want 1 3", o_st0, o_stall); end
    n_tests++; if (o_wb !== 32'hFFFFF00D) begin n_fail++; $display("FAIL b2b_lh_wb got %h want fffff00d", o_wb); end
  endtask

  task automatic test_random;
    logic [5:0] ops [8];
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int it = 0; it < 40; it++) begin
      int unsigned idx = $urandom_range(0, 7);
      logic [5:0] o = ops[idx];
      logic rd = (idx < 5);
      int unsigned n = nbytes(o);
      logic [31:0] a = $urandom, sd = $urandom, rdat = $urandom;
      int ack = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      int ereq;
      logic [31:0] ewb;
      if ($urandom_range(0, 3) != 0) a = a & ~(n - 1);
      mem_txn(o, rd, !rd, a, sd, rdat, ack);
      if (a % n != 0) begin
        n_tests++; if (o_aerr !== 1'b1 || o_req !== 0 || o_stall !== 0 || o_wb !== 32'h0) begin
          n_fail++; $display("FAIL rnd_mis op=%h a=%h got aerr=%b req=%0d stall=%0d wb=%h want 1 0 0 0", o, a, o_aerr, o_req, o_stall, o_wb); end
      end else begin
        ereq = (ack == 0) ? int'(TO) : ack;
        ewb = !rd ? a : (ack == 0) ? 32'h0 : exp_load(o, a, rdat);
        n_tests++; if (o_aerr !== 1'b0 || o_req !== ereq || o_stall !== ereq + 1) begin
          n_fail++; $display("FAIL rnd_lat op=%h got aerr=%b req=%0d stall=%0d want 0 %0d %0d", o, o_aerr, o_req, o_stall, ereq, ereq + 1); end
        n_tests++; if (o_addr !== {a[31:2], 2'b00} || o_be !== exp_be(o, a) || o_we !== !rd) begin
          n_fail++; $display("FAIL rnd_bus op=%h a=%h got addr=%h be=%h we=%b want %h %h %b", o, a, o_addr, o_be, o_we, {a[31:2], 2'b00}, exp_be(o, a), !rd); end
        if (!rd) begin
          n_tests++; if (o_wdata !== exp_wdata(o, sd)) begin n_fail++; $display("FAIL rnd_wdata op=%h got %h want %h", o, o_wdata, exp_wdata(o, sd)); end
        end
        n_tests++; if (o_done !== 1'b1 || o_wb !== ewb || o_berr !== (ack == 0) || o_early !== 1'b0 || o_leak !== 1'b0) begin
          n_fail++; $display("FAIL rnd_done op=%h a=%h got done=%b wb=%h berr=%b early=%b leak=%b want 1 %h %b 0 0", o, a, o_done, o_wb, o_berr, o_early, o_leak, ewb, ack == 0); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_sw;
    test_load_byte;
    test_half;
    test_timeout;
    test_nonmem;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
